// File: rtl/bist_defs_pkg.sv
// Shared BIST definitions used by both the stimulus generator and the
// output signature analyzer so the two ends of the datapath stay paired.
//   - bist_state_t : session FSM encoding (IDLE/COMPACT/CHECK/DONE)
//   - DEF_*        : default MISR geometry, feedback taps and seed
package bist_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_t;

    localparam int unsigned DEF_MISR_W      = 5;
    localparam int unsigned DEF_RESP_W      = 4;
    localparam logic [4:0]  DEF_TAPS        = 5'b01001;
    localparam logic [4:0]  DEF_SEED        = 5'b00000;
    localparam int unsigned DEF_NUM_VECTORS = 4;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register.
// Ports:
//   clock          in   posedge clock
//   reset_internal in   synchronous active-high reset (loads SEED)
//   load           in   reload SEED (takes priority over enable)
//   enable         in   fold response into the signature this cycle
//   response       in   RESP_W response vector, XORed into sig[RESP_W-1:0]
//   signature      out  MISR_W current register contents
module misr_core
    import bist_defs_pkg::*;
#(
    parameter int unsigned       MISR_W = DEF_MISR_W,
    parameter int unsigned       RESP_W = DEF_RESP_W,
    parameter logic [MISR_W-1:0] TAPS   = DEF_TAPS,
    parameter logic [MISR_W-1:0] SEED   = DEF_SEED
) (
    input  logic              clock,
    input  logic              reset_internal,
    input  logic              load,
    input  logic              enable,
    input  logic [RESP_W-1:0] response,
    output logic [MISR_W-1:0] signature
);

    logic [MISR_W-1:0] sig_d, sig_q;
    logic [MISR_W-1:0] resp_ext;
    logic              fb;

    always_comb begin
        resp_ext = '0;
        resp_ext[RESP_W-1:0] = response;
        fb = ^(sig_q & TAPS);
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (enable) begin
            // Shift right with feedback into the MSB, then fold the response in.
            sig_d = {fb, sig_q[MISR_W-1:1]} ^ resp_ext;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_internal) sig_q <= SEED;
        else                sig_q <= sig_d;
    end

    assign signature = sig_q;

endmodule

// File: rtl/output_signature_analyzer.sv
// Response-compaction end of the BIST datapath. Folds NUM_VECTORS captured
// CUT responses into a MISR, then compares against a golden signature.
// Ports:
//   clock          in   posedge clock
//   reset_internal in   synchronous active-high reset, wins over everything
//   start          in   begin a session (honoured in IDLE or DONE only)
//   control_output in   capture enable: response valid this cycle
//   response       in   RESP_W CUT response
//   golden         in   MISR_W expected signature, sampled in CHECK
//   signature      out  current MISR contents
//   busy           out  high in COMPACT and CHECK
//   done           out  high while in DONE
//   pass           out  signature==golden result, valid while done=1
module output_signature_analyzer
    import bist_defs_pkg::*;
#(
    parameter int unsigned       MISR_W      = DEF_MISR_W,
    parameter int unsigned       RESP_W      = DEF_RESP_W,
    parameter logic [MISR_W-1:0] TAPS        = DEF_TAPS,
    parameter logic [MISR_W-1:0] SEED        = DEF_SEED,
    parameter int unsigned       NUM_VECTORS = DEF_NUM_VECTORS
) (
    input  logic              clock,
    input  logic              reset_internal,
    input  logic              start,
    input  logic              control_output,
    input  logic [RESP_W-1:0] response,
    input  logic [MISR_W-1:0] golden,
    output logic [MISR_W-1:0] signature,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int unsigned      CNT_W = $clog2(NUM_VECTORS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_VECTORS - 1);

    bist_state_t      state_d, state_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             pass_d, pass_q;
    logic             misr_load, misr_en;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_COMPACT;
                    count_d   = '0;
                    misr_load = 1'b1;
                end
            end
            ST_COMPACT: begin
                // control_output low is a stall: signature and count hold.
                if (control_output) begin
                    misr_en = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                pass_d  = (signature == golden);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_COMPACT;
                    count_d   = '0;
                    pass_d    = 1'b0;
                    misr_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_internal) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    misr_core #(
        .MISR_W (MISR_W),
        .RESP_W (RESP_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_misr (
        .clock          (clock),
        .reset_internal (reset_internal),
        .load           (misr_load),
        .enable         (misr_en),
        .response       (response),
        .signature      (signature)
    );

    assign busy = (state_q == ST_COMPACT) || (state_q == ST_CHECK);
    assign done = (state_q == ST_DONE);
    assign pass = pass_q;

endmodule
